operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Effective-address sequencer that sits directly upstream of the ALU. After decode it fetches operand/pointer bytes over a byte-wide memory port and drives op_A/op_B/alu_op into the ALU for index additions. It samples the combinational ALU result in the same cycle and delivers the final 16-bit effective address (or immediate value) plus the updated PC to the execute stage.

Parameters:
ADDR_W, 16, address/operand width; only 16 is supported.
DATA_W, 8, memory data width; only 8 is supported.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
start_i  in  1  begin a fetch; sampled only in IDLE
mode_i  in  addr_mode_t  addressing mode, sampled with start_i
pc_i  in  16  address of first operand byte
x_i  in  8  X index, sampled with start_i
y_i  in  8  Y index, sampled with start_i
mem_req_o  out  1  memory read request
mem_addr_o  out  16  read address; stable while mem_req_o is high
mem_rdata_i  in  8  read data, valid with mem_rvalid_i
mem_rvalid_i  in  1  read completion
alu_op_o  out  alu_op_t  ALU operation
op_a_o  out  16  ALU operand A
op_b_o  out  16  ALU operand B
alu_res_i  in  16  ALU result, same cycle
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse; ea_o/pc_next_o/page_cross_o valid
ea_o  out  16  effective address, or {8'h00,imm} for IMMEDIATE
pc_next_o  out  16  pc_i + number of operand bytes consumed (0/1/2)
page_cross_o  out  1  ABS_X/ABS_Y/IND_Y: carry out of the low-byte add

Behaviour:
- Reset (async, any state): state=IDLE. mem_req_o=0, mem_addr_o=0, alu_op_o=ALU_BYPASS_A, op_a_o=op_b_o=0, busy_o=0, done_o=0, ea_o=0, pc_next_o=0, page_cross_o=0. mem_req_o drops in the same cycle reset asserts; a late mem_rvalid_i is ignored.
- States: IDLE, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, INDEX, DONE.
- In IDLE, start_i=1 latches mode, pc, x, y and moves to the first state for that mode. start_i is ignored in all other states.
- Mode sequences:
  - IMPLIED: DONE.
  - IMMEDIATE, ZEROPAGE: FETCH_LO, DONE.
  - ZP_X, ZP_Y: FETCH_LO, INDEX, DONE.
  - ABSOLUTE: FETCH_LO, FETCH_HI, DONE.
  - ABS_X, ABS_Y: FETCH_LO, FETCH_HI, INDEX, DONE.
  - IND_X: FETCH_LO, INDEX, PTR_LO, PTR_HI, DONE.
  - IND_Y: FETCH_LO, PTR_LO, PTR_HI, INDEX, DONE.
- Fetch states:
  - FETCH_LO reads pc. FETCH_HI reads pc+1 (16-bit wrap, FFFF->0000).
  - PTR_LO reads {8'h00,p}. PTR_HI reads {8'h00,p+1}, 8-bit wrap (FF->00). p is the fetched zp byte (IND_Y) or the INDEX result (IND_X).
  - Each fetch state holds mem_req_o=1 and a stable address until a cycle with mem_rvalid_i=1. It captures mem_rdata_i and advances on that edge.
  - mem_rvalid_i in the same cycle as the request is legal, giving one cycle per fetch. mem_rvalid_i while mem_req_o=0 is ignored.
- INDEX: exactly one cycle; alu_res_i is captured at the edge.
  - ZP_X/ZP_Y/IND_X: ALU_ADD_ZEROPAGE, op_a={00,byte}, op_b={00,X or Y}. High byte of the result is 00 (page wrap).
  - ABS_X/ABS_Y/IND_Y: ALU_ADD, op_a=assembled 16-bit address, op_b={00,X or Y}. page_cross = (op_a[7:0]+index) > 8'hFF.
  - Outside INDEX: alu_op_o=ALU_BYPASS_A, op_a_o=op_b_o=0.
- DONE:
  - done_o=1 for one cycle, then return to IDLE.
  - ea_o, pc_next_o and page_cross_o update entering DONE and hold until the next DONE or reset.
  - page_cross_o=0 for modes without a 16-bit index add.
- Latency from the start_i edge to the done_o cycle, with zero-wait memory, equals the number of states in the mode's sequence: IMPLIED 1, ABSOLUTE 3, IND_X 5.

Decomposition:
- Shared package: addr_mode_t enum (IMPLIED, IMMEDIATE, ZEROPAGE, ZP_X, ZP_Y, ABSOLUTE, ABS_X, ABS_Y, IND_X, IND_Y) and fetch_state_t.
- Reuse the existing alu_op_t and `BYTE` from the existing package.
- No sub-module: a single FSM with an inline datapath.

Test Plan:
- IMMEDIATE, pc_i=0x8000, mem[0x8000]=0x42, zero-wait -> one request at 0x8000; done_o 2 cycles after start; ea_o=0x0042, pc_next_o=0x8001.
- ABS_X, pc_i=0x8000, bytes F0 12, x_i=0x20 -> alu_op_o=ALU_ADD, op_a=0x12F0, op_b=0x0020; ea_o=0x1310, page_cross_o=1, pc_next_o=0x8002.
- ZP_X, zp=0xF0, x_i=0x20 -> ALU_ADD_ZEROPAGE; ea_o=0x0010, page_cross_o=0.
- IND_X, zp=0xFE, x_i=0x01, mem[00FF]=0x34, mem[0000]=0x12 -> reads 8000, 00FF, 0000; ea_o=0x1234.
- IND_Y, zp=0x10, mem[0010]=0xFF, mem[0011]=0x20, y_i=0x01, rvalid delayed 3 cycles per read -> mem_addr_o stable while waiting; ea_o=0x2100, page_cross_o=1.
- Reset asserted mid-PTR_LO, plus start_i pulsed while busy -> outputs zero immediately, next start is clean; the start pulsed while busy has no effect.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch sequencer.
//   addr_mode_t   : addressing mode presented by decode
//   alu_op_t      : operation requested from the downstream ALU
//   fetch_state_t : sequencer states
// Helper functions classify modes by index register, add width and operand bytes.
package operand_fetch_pkg;

  localparam int unsigned BYTE = 8;

  typedef enum logic [1:0] {
    ALU_BYPASS_A,
    ALU_ADD,
    ALU_ADD_ZEROPAGE
  } alu_op_t;

  typedef enum logic [3:0] {
    IMPLIED,
    IMMEDIATE,
    ZEROPAGE,
    ZP_X,
    ZP_Y,
    ABSOLUTE,
    ABS_X,
    ABS_Y,
    IND_X,
    IND_Y
  } addr_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetchLo,
    StFetchHi,
    StPtrLo,
    StPtrHi,
    StIndex,
    StDone
  } fetch_state_t;

  // Modes whose index step wraps inside page zero.
  function automatic logic is_zp_index(input addr_mode_t mode);
    return (mode == ZP_X) || (mode == ZP_Y) || (mode == IND_X);
  endfunction

  function automatic logic uses_x(input addr_mode_t mode);
    return (mode == ZP_X) || (mode == ABS_X) || (mode == IND_X);
  endfunction

  // Operand bytes consumed from the instruction stream.
  function automatic logic [15:0] operand_bytes(input addr_mode_t mode);
    unique case (mode)
      IMPLIED:                 return 16'd0;
      ABSOLUTE, ABS_X, ABS_Y:  return 16'd2;
      default:                 return 16'd1;
    endcase
  endfunction

endpackage

// File: rtl/operand_fetch.sv
// Effective-address sequencer between decode and execute.
// Fetches operand/pointer bytes over a byte-wide read port, uses the external
// combinational ALU for index additions and reports the final address.
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   start_i, mode_i, pc_i,    fetch request and operands (sampled in IDLE)
//   x_i, y_i
//   mem_req_o, mem_addr_o,    byte read port; address held until mem_rvalid_i
//   mem_rdata_i, mem_rvalid_i
//   alu_op_o, op_a_o, op_b_o, ALU request (driven only in INDEX) and its result
//   alu_res_i
//   busy_o, done_o            status; done_o pulses when results are valid
//   ea_o, pc_next_o,          effective address / immediate, updated PC,
//   page_cross_o              carry out of the low byte for 16-bit index adds
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  addr_mode_t        mode_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output alu_op_t           alu_op_o,
  output logic [ADDR_W-1:0] op_a_o,
  output logic [ADDR_W-1:0] op_b_o,
  input  logic [ADDR_W-1:0] alu_res_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ea_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              page_cross_o
);

  fetch_state_t      state_q, state_d;
  addr_mode_t        mode_q, mode_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [BYTE-1:0]   x_q, x_d, y_q, y_d;
  // Assembled byte/address; becomes the effective address on entry to DONE.
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Zero-page pointer used by the PTR states.
  logic [BYTE-1:0]   ptr_q, ptr_d;
  logic              pcross_q, pcross_d;
  logic [BYTE-1:0]   idx;
  logic [BYTE:0]     low_sum;

  logic [ADDR_W-1:0] ea_q, pc_next_q;
  logic              page_cross_q;

  assign idx     = uses_x(mode_q) ? x_q : y_q;
  assign low_sum = {1'b0, addr_q[7:0]} + {1'b0, idx};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pc_d       = pc_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    ptr_d      = ptr_q;
    pcross_d   = pcross_q;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    alu_op_o   = ALU_BYPASS_A;
    op_a_o     = '0;
    op_b_o     = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d   = mode_i;
          pc_d     = pc_i;
          x_d      = x_i;
          y_d      = y_i;
          addr_d   = '0;
          pcross_d = 1'b0;
          state_d  = (mode_i == IMPLIED) ? StDone : StFetchLo;
        end
      end
      StFetchLo: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc_q;
        if (mem_rvalid_i) begin
          addr_d = {8'h00, mem_rdata_i};
          ptr_d  = mem_rdata_i;
          unique case (mode_q)
            ZP_X, ZP_Y, IND_X:       state_d = StIndex;
            ABSOLUTE, ABS_X, ABS_Y:  state_d = StFetchHi;
            IND_Y:                   state_d = StPtrLo;
            default:                 state_d = StDone;
          endcase
        end
      end
      StFetchHi: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc_q + 16'd1;
        if (mem_rvalid_i) begin
          addr_d[15:8] = mem_rdata_i;
          state_d      = (mode_q == ABSOLUTE) ? StDone : StIndex;
        end
      end
      StPtrLo: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {8'h00, ptr_q};
        if (mem_rvalid_i) begin
          addr_d[7:0] = mem_rdata_i;
          state_d     = StPtrHi;
        end
      end
      StPtrHi: begin
        mem_req_o  = 1'b1;
        // Pointer increment wraps within page zero.
        mem_addr_o = {8'h00, ptr_q + 8'd1};
        if (mem_rvalid_i) begin
          addr_d[15:8] = mem_rdata_i;
          state_d      = (mode_q == IND_Y) ? StIndex : StDone;
        end
      end
      StIndex: begin
        op_b_o = {8'h00, idx};
        if (is_zp_index(mode_q)) begin
          alu_op_o = ALU_ADD_ZEROPAGE;
          op_a_o   = {8'h00, addr_q[7:0]};
          addr_d   = {8'h00, alu_res_i[7:0]};
          ptr_d    = alu_res_i[7:0];
          state_d  = (mode_q == IND_X) ? StPtrLo : StDone;
        end else begin
          alu_op_o = ALU_ADD;
          op_a_o   = addr_q;
          addr_d   = alu_res_i;
          pcross_d = low_sum[8];
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      mode_q   <= IMPLIED;
      pc_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      ptr_q    <= '0;
      pcross_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pc_q     <= pc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      ptr_q    <= ptr_d;
      pcross_q <= pcross_d;
    end
  end

  // Results load on the edge into DONE and hold until the next DONE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ea_q         <= '0;
      pc_next_q    <= '0;
      page_cross_q <= 1'b0;
    end else if (state_d == StDone) begin
      ea_q         <= addr_d;
      pc_next_q    <= pc_d + operand_bytes(mode_d);
      page_cross_q <= pcross_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign ea_o         = ea_q;
  assign pc_next_o    = pc_next_q;
  assign page_cross_o = page_cross_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a byte memory with programmable wait
// states, a behavioural ALU, and a reference model that derives reads, ALU
// requests and results directly from the addressing-mode rules.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  addr_mode_t  mode_i = IMPLIED;
  logic [15:0] pc_i = '0;
  logic [7:0]  x_i = '0, y_i = '0;
  logic        mem_req_o, mem_rvalid_i;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  alu_op_t     alu_op_o;
  logic [15:0] op_a_o, op_b_o, alu_res_i;
  logic        busy_o, done_o, page_cross_o;
  logic [15:0] ea_o, pc_next_o;

  operand_fetch dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .mode_i(mode_i), .pc_i(pc_i),
    .x_i(x_i), .y_i(y_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .alu_op_o(alu_op_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .alu_res_i(alu_res_i), .busy_o(busy_o),
    .done_o(done_o), .ea_o(ea_o), .pc_next_o(pc_next_o), .page_cross_o(page_cross_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural ALU.
  always_comb begin
    case (alu_op_o)
      ALU_ADD:          alu_res_i = op_a_o + op_b_o;
      ALU_ADD_ZEROPAGE: alu_res_i = {8'h00, op_a_o[7:0] + op_b_o[7:0]};
      default:          alu_res_i = op_a_o;
    endcase
  end

  // Memory with wait states.
  logic [7:0] mem [0:65535];
  int  delay_cfg = 0;
  bit  rand_delay = 1'b0;
  int  wait_cnt;

  function automatic int pick_delay();
    if (rand_delay) return int'($urandom_range(0, delay_cfg));
    return delay_cfg;
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) wait_cnt <= 0;
    else if (!mem_req_o || mem_rvalid_i) wait_cnt <= pick_delay();
    else wait_cnt <= wait_cnt - 1;
  end
  assign mem_rvalid_i = mem_req_o && (wait_cnt == 0);
  assign mem_rdata_i  = mem[mem_addr_o];

  // Scoreboard.
  typedef struct {
    logic [15:0] ea;
    logic [15:0] pcn;
    logic        pcross;
    int          lat;
    int          start;
  } exp_t;
  typedef struct {
    alu_op_t     op;
    logic [15:0] a;
    logic [15:0] b;
  } alu_exp_t;

  exp_t        sb_q[$];
  logic [15:0] rd_q[$];
  alu_exp_t    alu_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected reads, ALU request and final result per mode.
  task automatic model(input addr_mode_t m, input logic [15:0] pc, input logic [7:0] x,
                       input logic [7:0] y, output exp_t e);
    logic [7:0]  zp, p, idx;
    logic [15:0] base, pc1;
    int          nrd0, nalu0;
    nrd0  = rd_q.size();
    nalu0 = alu_q.size();
    idx   = (m == ZP_X || m == ABS_X || m == IND_X) ? x : y;
    pc1   = pc + 16'd1;
    zp    = mem[pc];
    e.pcross = 1'b0;
    e.pcn    = pc + 16'd1;
    e.ea     = 16'h0000;
    case (m)
      IMPLIED: e.pcn = pc;
      IMMEDIATE, ZEROPAGE: begin
        rd_q.push_back(pc);
        e.ea = {8'h00, zp};
      end
      ZP_X, ZP_Y: begin
        rd_q.push_back(pc);
        p = zp + idx;
        e.ea = {8'h00, p};
        alu_q.push_back('{ALU_ADD_ZEROPAGE, {8'h00, zp}, {8'h00, idx}});
      end
      ABSOLUTE, ABS_X, ABS_Y: begin
        rd_q.push_back(pc);
        rd_q.push_back(pc1);
        base  = {mem[pc1], zp};
        e.pcn = pc + 16'd2;
        e.ea  = base;
        if (m != ABSOLUTE) begin
          e.ea     = base + {8'h00, idx};
          e.pcross = (int'(base[7:0]) + int'(idx)) > 255;
          alu_q.push_back('{ALU_ADD, base, {8'h00, idx}});
        end
      end
      IND_X: begin
        p = zp + idx;
        rd_q.push_back(pc);
        rd_q.push_back({8'h00, p});
        rd_q.push_back({8'h00, p + 8'd1});
        alu_q.push_back('{ALU_ADD_ZEROPAGE, {8'h00, zp}, {8'h00, idx}});
        e.ea = {mem[{8'h00, p + 8'd1}], mem[{8'h00, p}]};
      end
      default: begin // IND_Y
        rd_q.push_back(pc);
        rd_q.push_back({8'h00, zp});
        rd_q.push_back({8'h00, zp + 8'd1});
        base     = {mem[{8'h00, zp + 8'd1}], mem[{8'h00, zp}]};
        e.ea     = base + {8'h00, y};
        e.pcross = (int'(base[7:0]) + int'(y)) > 255;
        alu_q.push_back('{ALU_ADD, base, {8'h00, y}});
      end
    endcase
    // Zero-wait latency: one cycle per state in the mode's sequence.
    e.lat = (delay_cfg == 0) ? 1 + (rd_q.size() - nrd0) + (alu_q.size() - nalu0) : -1;
  endtask

  // Monitor.
  initial begin
    bit          req_wait;
    logic [15:0] prev_addr;
    exp_t        e;
    alu_exp_t    a;
    req_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        req_wait = 1'b0;
      end else begin
        if (mem_req_o && req_wait) check("addr_stable", {16'h0, mem_addr_o}, {16'h0, prev_addr});
        if (mem_req_o && mem_rvalid_i) begin
          if (rd_q.size() == 0) check("unexpected_read", {16'h0, mem_addr_o}, 32'hFFFF_FFFF);
          else check("read_addr", {16'h0, mem_addr_o}, {16'h0, rd_q.pop_front()});
        end
        req_wait  = mem_req_o && !mem_rvalid_i;
        prev_addr = mem_addr_o;
        if (alu_op_o != ALU_BYPASS_A) begin
          if (alu_q.size() == 0) check("unexpected_alu", {30'h0, alu_op_o}, 32'hFFFF_FFFF);
          else begin
            a = alu_q.pop_front();
            check("alu_op", {30'h0, alu_op_o}, {30'h0, a.op});
            check("alu_ops", {op_a_o, op_b_o}, {a.a, a.b});
          end
        end else begin
          check("alu_idle_ops", {op_a_o, op_b_o}, 32'h0);
        end
        if (done_o) begin
          if (sb_q.size() == 0) check("unexpected_done", 32'h1, 32'h0);
          else begin
            e = sb_q.pop_front();
            check("ea", {16'h0, ea_o}, {16'h0, e.ea});
            check("pc_next", {16'h0, pc_next_o}, {16'h0, e.pcn});
            check("page_cross", {31'h0, page_cross_o}, {31'h0, e.pcross});
            if (e.lat > 0) check("latency", cyc - e.start + 1, e.lat);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {15'h0, mem_req_o, mem_addr_o}, 32'h0);
    check({tag, "_busy_done"}, {30'h0, busy_o, done_o}, 32'h0);
    check({tag, "_ea_pcn"}, {ea_o, pc_next_o}, 32'h0);
    check({tag, "_pcross"}, {31'h0, page_cross_o}, 32'h0);
    check({tag, "_alu"}, {30'h0, alu_op_o}, {30'h0, ALU_BYPASS_A});
    check({tag, "_ops"}, {op_a_o, op_b_o}, 32'h0);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic start_op(input addr_mode_t m, input logic [15:0] pc, input logic [7:0] x,
                          input logic [7:0] y, input bit pulse_busy);
    exp_t e;
    mode_i = m; pc_i = pc; x_i = x; y_i = y; start_i = 1'b1;
    model(m, pc, x, y, e);
    e.start = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk_i);
    start_i = 1'b0;
    if (pulse_busy && busy_o) begin
      mode_i = addr_mode_t'($urandom_range(0, 9));
      pc_i = 16'($urandom); x_i = 8'($urandom); y_i = 8'($urandom);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) begin
      check("timeout_busy", 32'h1, 32'h0);
      $display("FAIL timeout: DUT stuck busy, aborting");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
    end
  endtask

  task automatic run_op(input addr_mode_t m, input logic [15:0] pc, input logic [7:0] x,
                        input logic [7:0] y, input bit pulse_busy);
    start_op(m, pc, x, y, pulse_busy);
    wait_idle();
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Directed cases, zero-wait memory.
    mem[16'h8000] = 8'h42;
    run_op(IMMEDIATE, 16'h8000, 8'h00, 8'h00, 1'b0);
    run_op(IMPLIED, 16'h1234, 8'h00, 8'h00, 1'b1);
    mem[16'h8000] = 8'hF0; mem[16'h8001] = 8'h12;
    run_op(ABS_X, 16'h8000, 8'h20, 8'h00, 1'b1);
    run_op(ABSOLUTE, 16'h8000, 8'h00, 8'h00, 1'b0);
    run_op(ZP_X, 16'h8000, 8'h20, 8'h00, 1'b0);
    mem[16'h8000] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    run_op(IND_X, 16'h8000, 8'h01, 8'h00, 1'b1);
    run_op(ABSOLUTE, 16'hFFFF, 8'h00, 8'h00, 1'b0);

    // IND_Y with three wait cycles per read.
    delay_cfg = 3;
    mem[16'h8000] = 8'h10; mem[16'h0010] = 8'hFF; mem[16'h0011] = 8'h20;
    run_op(IND_Y, 16'h8000, 8'h00, 8'h01, 1'b1);

    // Reset in PTR_LO, with a start pulsed while busy.
    start_op(IND_Y, 16'h8000, 8'h00, 8'h01, 1'b1);
    n = 0;
    while (!(mem_req_o && mem_addr_o == 16'h0010) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_ptr_lo", {31'h0, mem_req_o && mem_addr_o == 16'h0010}, 32'h1);
    #1 rstn_i = 1'b0;
    #1 check_reset_outputs("mid_reset");
    sb_q.delete(); rd_q.delete(); alu_q.delete();
    @(negedge clk_i);
    check_reset_outputs("held_reset");
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    delay_cfg = 0;
    run_op(IND_Y, 16'h8000, 8'h00, 8'h01, 1'b0);

    // Randomized traffic.
    rand_delay = 1'b1;
    for (int i = 0; i < 80; i++) begin
      delay_cfg = (i < 40) ? 0 : 3;
      run_op(addr_mode_t'($urandom_range(0, 9)), 16'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom));
    end

    check("sb_drained", sb_q.size() + rd_q.size() + alu_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
